// File: rtl/cic3_decimator.sv
// cic3_decimator: third-order CIC (sinc^3) decimator for a 1-bit delta-sigma stream.
// Decimates by R = 2**DECIM_LOG2 and produces signed OUT_WIDTH-bit PCM samples.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst      asynchronous active-high reset, clears all state
//   i_en       sample strobe; i_bit is consumed only when high
//   i_clear    synchronous restart, same effect as reset, wins over i_en
//   i_bit      modulator bitstream (1 -> +1, 0 -> -1)
//   o_data     signed decimated sample, held between o_valid pulses
//   o_valid    one-cycle pulse, one clock after the decimation tick
//   o_settled  high from the 4th o_valid until reset/clear
module cic3_decimator #(
    parameter int unsigned DECIM_LOG2 = 5,
    parameter int unsigned OUT_WIDTH  = 2 + 3 * DECIM_LOG2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_clear,
    input  logic                 i_bit,
    output logic [OUT_WIDTH-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_settled
);

    if (DECIM_LOG2 < 1 || DECIM_LOG2 > 8) begin : g_bad_decim
        $error("cic3_decimator: DECIM_LOG2 must be in 1..8");
    end
    if (OUT_WIDTH < 2 + 3 * DECIM_LOG2) begin : g_bad_width
        $error("cic3_decimator: OUT_WIDTH too small for the CIC bit growth");
    end

    logic [OUT_WIDTH-1:0]  i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
    logic [OUT_WIDTH-1:0]  d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic [OUT_WIDTH-1:0]  data_q, data_d;
    logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
    logic [2:0]            out_cnt_q, out_cnt_d;
    logic                  valid_q, valid_d;
    logic                  settled_q, settled_d;

    logic [OUT_WIDTH-1:0]  x;
    logic [OUT_WIDTH-1:0]  s, c1, c2, c3;
    logic                  tick;

    // +1 / -1 in two's complement
    assign x    = i_bit ? OUT_WIDTH'(1) : '1;
    assign tick = i_en && (cnt_q == '1);

    // Comb input is the post-update I3; all arithmetic wraps modulo 2^OUT_WIDTH,
    // the comb differences undo any integrator overflow.
    assign s  = i3_q + i2_q;
    assign c1 = s - d1_q;
    assign c2 = c1 - d2_q;
    assign c3 = c2 - d3_q;

    always_comb begin
        i1_d      = i1_q;
        i2_d      = i2_q;
        i3_d      = i3_q;
        d1_d      = d1_q;
        d2_d      = d2_q;
        d3_d      = d3_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        out_cnt_d = out_cnt_q;
        valid_d   = 1'b0;
        settled_d = settled_q;

        if (i_clear) begin
            i1_d      = '0;
            i2_d      = '0;
            i3_d      = '0;
            d1_d      = '0;
            d2_d      = '0;
            d3_d      = '0;
            data_d    = '0;
            cnt_d     = '0;
            out_cnt_d = '0;
            settled_d = 1'b0;
        end else if (i_en) begin
            i1_d  = i1_q + x;
            i2_d  = i2_q + i1_q;
            i3_d  = i3_q + i2_q;
            cnt_d = cnt_q + DECIM_LOG2'(1);
            if (tick) begin
                d1_d    = s;
                d2_d    = c1;
                d3_d    = c2;
                data_d  = c3;
                valid_d = 1'b1;
                // Counted at the tick so the count and settled flag land with o_valid.
                if (out_cnt_q != 3'd4) begin
                    out_cnt_d = out_cnt_q + 3'd1;
                end
                if (out_cnt_q == 3'd3) begin
                    settled_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            i1_q      <= '0;
            i2_q      <= '0;
            i3_q      <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
            d3_q      <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            out_cnt_q <= '0;
            valid_q   <= 1'b0;
            settled_q <= 1'b0;
        end else begin
            i1_q      <= i1_d;
            i2_q      <= i2_d;
            i3_q      <= i3_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            d3_q      <= d3_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            out_cnt_q <= out_cnt_d;
            valid_q   <= valid_d;
            settled_q <= settled_d;
        end
    end

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_settled = settled_q;

endmodule

// File: tb/tb_cic3_decimator.sv
// tb_cic3_decimator: scoreboard bench for cic3_decimator at default parameters.
// Expected samples come from a direct FIR model (triple boxcar convolution, delayed
// by two input samples) and are queued when the tick-producing bit is driven.
module tb_cic3_decimator;

    localparam int DECIM_LOG2 = 5;
    localparam int W          = 2 + 3 * DECIM_LOG2;
    localparam int R          = 1 << DECIM_LOG2;
    localparam int HLEN       = 3 * R - 2;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_en = 1'b0;
    logic         i_clear = 1'b0;
    logic         i_bit = 1'b0;
    logic [W-1:0] o_data;
    logic         o_valid;
    logic         o_settled;

    cic3_decimator #(
        .DECIM_LOG2 (DECIM_LOG2),
        .OUT_WIDTH  (W)
    ) u_dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en      (i_en),
        .i_clear   (i_clear),
        .i_bit     (i_bit),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .o_settled (o_settled)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int hist[$];
    int sb_q[$];
    int n_ticks = 0;
    int held = 0;
    int b2[2*R-1];
    int b3[HLEN];

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // y(n) = sum_j b3[j] * x(n-2-j), inputs before restart are zero
    function automatic int model_y();
        int acc = 0;
        int last = hist.size() - 1;
        for (int j = 0; j < HLEN; j++) begin
            int idx = last - 2 - j;
            if (idx >= 0) acc += b3[j] * hist[idx];
        end
        return acc;
    endfunction

    task automatic model_reset();
        hist.delete();
        sb_q.delete();
        n_ticks = 0;
        held = 0;
    endtask

    task automatic step(input logic en, input logic b);
        int tick = 0;
        int exp_y;
        i_en  = en;
        i_bit = b;
        if (en) begin
            hist.push_back(b ? 1 : -1);
            if (hist.size() % R == 0) begin
                sb_q.push_back(model_y());
                n_ticks++;
                tick = 1;
            end
        end
        @(posedge i_clk);
        #1;
        check("valid", int'(o_valid), tick);
        if (o_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_nonempty", 0, 1);
            end else begin
                exp_y = sb_q.pop_front();
                held  = exp_y;
                check("data", $signed(o_data), exp_y);
            end
        end else begin
            check("hold", $signed(o_data), held);
        end
        check("settled", int'(o_settled), int'(n_ticks >= 4));
    endtask

    task automatic run(input logic [3:0] pat, input int plen, input int nen, input int gap);
        for (int k = 0; k < nen; k++) begin
            step(1'b1, pat[k % plen]);
            for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_data"}, $signed(o_data), 0);
        check({tag, "_valid"}, int'(o_valid), 0);
        check({tag, "_settled"}, int'(o_settled), 0);
    endtask

    task automatic do_clear(input logic b);
        i_clear = 1'b1;
        i_en    = 1'b1;
        i_bit   = b;
        @(posedge i_clk);
        #1;
        i_clear = 1'b0;
        i_en    = 1'b0;
        model_reset();
        check_cleared("clear");
    endtask

    task automatic do_async_reset();
        #2;
        i_en  = 1'b0;
        i_rst = 1'b1;
        #1;
        check_cleared("async_rst");
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        model_reset();
    endtask

    initial begin
        for (int k = 0; k < 2 * R - 1; k++) begin
            b2[k] = 0;
            for (int i = 0; i < R; i++) if (k - i >= 0 && k - i < R) b2[k] += 1;
        end
        for (int k = 0; k < HLEN; k++) begin
            b3[k] = 0;
            for (int i = 0; i < R; i++) if (k - i >= 0 && k - i < 2 * R - 1) b3[k] += b2[k - i];
        end

        #12;
        check_cleared("reset");
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        model_reset();

        run(4'b1111, 1, 6 * R, 0);
        check("ones_final", $signed(o_data), 32768);

        do_clear(1'b1);
        run(4'b0000, 1, 6 * R, 0);
        check("zeros_final", $signed(o_data), -32768);

        do_clear(1'b0);
        run(4'b0101, 2, 6 * R, 0);
        check("alt10_final", $signed(o_data), 0);

        do_clear(1'b1);
        run(4'b0011, 4, 6 * R, 0);
        check("p1100_final", $signed(o_data), 0);

        do_clear(1'b1);
        run(4'b0111, 4, 6 * R, 0);
        check("p1110_final", $signed(o_data), 16384);

        do_clear(1'b0);
        run(4'b1111, 1, 6 * R, 2);
        check("sparse_final", $signed(o_data), 32768);

        // Mid-frame asynchronous reset after settling, then a fresh run
        do_clear(1'b1);
        run(4'b1111, 1, 4 * R + 12, 0);
        check("pre_rst_settled", int'(o_settled), 1);
        do_async_reset();
        run(4'b1111, 1, 6 * R, 0);
        check("post_rst_final", $signed(o_data), 32768);

        // Mid-frame synchronous clear, bit presented with the clear is discarded
        run(4'b1111, 1, 12, 0);
        do_clear(1'b0);
        run(4'b1111, 1, 6 * R, 0);
        check("post_clr_final", $signed(o_data), 32768);

        check("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
